// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver: pin synchronisation and glitch filtering, 11-bit frame capture,
// start/parity/stop checking, make/break tracking and a stretched active-low valid strobe.
module ps2_receiver #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT     = 100000,
  parameter int HOLD_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] sda_to_do,
  output logic        data_valid,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  function automatic logic odd_parity(input logic [8:0] v);
    return ^v;
  endfunction

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_flt_q, clk_flt_d, dat_flt_q, dat_flt_d, clk_prev_q;
  logic [FW-1:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
  state_t        state_q, state_d;
  logic [10:0]   shreg_q, shreg_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [10:0]   sda_q, sda_d;
  logic          valid_q, valid_d, err_q, err_d, brk_q, brk_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          fall_s, timeout_s, good_s;
  logic [7:0]    data_s;

  // A filtered level flips only once FILTER_LEN consecutive synced samples disagree with it
  always_comb begin
    clk_flt_d = clk_flt_q;
    clk_cnt_d = '0;
    if (clk_sync_q[1] != clk_flt_q) begin
      if (clk_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_flt_d = clk_sync_q[1];
        clk_cnt_d = '0;
      end else begin
        clk_cnt_d = clk_cnt_q + FW'(1);
      end
    end else begin
      clk_cnt_d = '0;
    end
    dat_flt_d = dat_flt_q;
    dat_cnt_d = '0;
    if (dat_sync_q[1] != dat_flt_q) begin
      if (dat_cnt_q == FW'(FILTER_LEN - 1)) begin
        dat_flt_d = dat_sync_q[1];
        dat_cnt_d = '0;
      end else begin
        dat_cnt_d = dat_cnt_q + FW'(1);
      end
    end else begin
      dat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_flt_q  <= 1'b1;
      dat_flt_q  <= 1'b1;
      clk_prev_q <= 1'b1;
      clk_cnt_q  <= '0;
      dat_cnt_q  <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      clk_flt_q  <= clk_flt_d;
      dat_flt_q  <= dat_flt_d;
      clk_prev_q <= clk_flt_q;
      clk_cnt_q  <= clk_cnt_d;
      dat_cnt_q  <= dat_cnt_d;
    end
  end

  assign fall_s    = clk_prev_q & ~clk_flt_q;
  assign timeout_s = (state_q == S_RECV) && !fall_s && (tmo_cnt_q == TW'(TIMEOUT));
  assign data_s    = shreg_q[8:1];
  assign good_s    = ~shreg_q[0] & shreg_q[10] & odd_parity(shreg_q[9:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= 4'd0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fall_s) state_d = S_RECV; else state_d = S_IDLE;
      S_RECV: begin
        if (fall_s && bit_cnt_q == 4'd10) state_d = S_CHECK;
        else if (timeout_s)               state_d = S_IDLE;
        else                              state_d = S_RECV;
      end
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Frame capture: data enters at bit 10 so the start bit ends up in bit 0
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      S_IDLE: begin
        tmo_cnt_d = '0;
        if (fall_s) begin
          shreg_d   = {dat_flt_q, shreg_q[10:1]};
          bit_cnt_d = 4'd1;
        end else begin
          bit_cnt_d = 4'd0;
        end
      end
      S_RECV: begin
        if (fall_s) begin
          shreg_d   = {dat_flt_q, shreg_q[10:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          tmo_cnt_d = '0;
        end else if (timeout_s) begin
          bit_cnt_d = 4'd0;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: begin
        bit_cnt_d = 4'd0;
        tmo_cnt_d = '0;
      end
    endcase
  end

  // Frame decode and hold stretching; a decode outcome overrides the running hold countdown
  always_comb begin
    sda_d   = sda_q;
    valid_d = valid_q;
    err_d   = timeout_s;
    brk_d   = brk_q;
    hold_d  = hold_q;
    if (!valid_q) begin
      if (hold_q == HW'(1)) begin
        valid_d = 1'b1;
        hold_d  = '0;
      end else begin
        hold_d  = hold_q - HW'(1);
      end
    end else begin
      hold_d = '0;
    end
    if (state_q == S_CHECK) begin
      if (!good_s) begin
        err_d = 1'b1;
        brk_d = 1'b0;
      end else if (data_s == 8'hE0) begin
        brk_d = brk_q;
      end else if (data_s == 8'hF0) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;
        if (data_s == sda_q[8:1] && !valid_q) begin
          valid_d = 1'b1;
          hold_d  = '0;
        end else begin
          valid_d = valid_d;
        end
      end else begin
        sda_d   = shreg_q;
        valid_d = 1'b0;
        hold_d  = HW'(HOLD_CYCLES);
      end
    end else begin
      brk_d = brk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sda_q   <= '0;
      valid_q <= 1'b1;
      err_q   <= 1'b0;
      brk_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      sda_q   <= sda_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      brk_q   <= brk_d;
      hold_q  <= hold_d;
    end
  end

  assign sda_to_do  = sda_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver: stimulus pushes expected events, a monitor pops them
// whenever the DUT reports an error pulse, a new held frame, or the end of a hold.
module tb_ps2_receiver;
  localparam int FL   = 8;
  localparam int TMO  = 300;
  localparam int HOLD = 1500;

  localparam logic [1:0] EV_ERR  = 2'd0;
  localparam logic [1:0] EV_MAKE = 2'd1;
  localparam logic [1:0] EV_END  = 2'd2;

  // Hand-built frames {stop, parity, data, start}
  localparam logic [10:0] F_1C     = 11'h438;
  localparam logic [10:0] F_1B_BAD = 11'h436;
  localparam logic [10:0] F_23     = 11'h446;
  localparam logic [10:0] F_F0     = 11'h7E0;
  localparam logic [10:0] F_2B     = 11'h656;
  localparam logic [10:0] F_34     = 11'h468;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst, ps2_clk, ps2_data;
  logic [10:0] sda_to_do;
  logic        data_valid, frame_err;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mon_en = 1'b0;

  logic        prev_valid;
  logic [10:0] prev_sda;
  int          low_cnt;

  always #5 clk = ~clk;

  ps2_receiver #(.FILTER_LEN(FL), .TIMEOUT(TMO), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .sda_to_do(sda_to_do), .data_valid(data_valid), .frame_err(frame_err)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] fr, input int nb);
    for (int i = 0; i < nb; i++) begin
      ps2_data = fr[i];
      cyc(10);
      ps2_clk = 1'b0;
      cyc(20);
      ps2_clk = 1'b1;
      cyc(10);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [10:0] fr);
    send_bits(fr, 11);
    cyc(40);
  endtask

  task automatic expect_ev(input logic [1:0] kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor-side comparison; an END expectation with val 0 does not check the hold length
  task automatic pop_cmp(input logic [1:0] kind, input int val);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d val %0h, expected no event at %0t", kind, val, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (e.val != val && !(kind == EV_END && e.val == 0))) begin
        n_bad++;
        $display("FAIL event_order: got kind %0d val %0h, expected kind %0d val %0h at %0t",
                 kind, val, e.kind, e.val, $time);
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cyc(1);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %0d expected events still pending, required 0 after %0d cycles",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_valid = 1'b1;
      prev_sda   = '0;
      low_cnt    = 0;
    end else begin
      if (frame_err !== 1'b0) pop_cmp(EV_ERR, 0);
      if (prev_valid === 1'b1 && data_valid === 1'b0) begin
        pop_cmp(EV_MAKE, int'(sda_to_do));
        low_cnt = 1;
      end else if (prev_valid === 1'b0 && data_valid === 1'b0 && sda_to_do !== prev_sda) begin
        pop_cmp(EV_MAKE, int'(sda_to_do));
        low_cnt = 1;
      end else if (data_valid === 1'b0) begin
        low_cnt = low_cnt + 1;
      end else begin
        if (prev_valid === 1'b0) pop_cmp(EV_END, low_cnt);
        low_cnt = 0;
      end
      prev_valid = data_valid;
      prev_sda   = sda_to_do;
    end
  end

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cyc(4);
    check("reset_sda", int'(sda_to_do), 0);
    check("reset_valid", int'(data_valid), 1);
    check("reset_err", int'(frame_err), 0);
    rst = 1'b0;
    cyc(2);
    mon_en = 1'b1;
    cyc(20);

    // Good make code, hold must last exactly HOLD cycles
    expect_ev(EV_MAKE, int'(F_1C));
    expect_ev(EV_END, HOLD);
    send_frame(F_1C);
    wait_drain("make_1C", HOLD + 200);

    // Parity error: single error pulse, valid untouched
    expect_ev(EV_ERR, 0);
    send_frame(F_1B_BAD);
    wait_drain("bad_parity", 200);
    check("bad_parity_valid", int'(data_valid), 1);

    // Make then break of the same key ends the hold early
    expect_ev(EV_MAKE, int'(F_23));
    send_frame(F_23);
    send_frame(F_F0);
    expect_ev(EV_END, 0);
    send_frame(F_23);
    wait_drain("release_23", 5);
    check("release_valid", int'(data_valid), 1);

    // Break of a different key leaves the hold running to its full length
    expect_ev(EV_MAKE, int'(F_23));
    expect_ev(EV_END, HOLD);
    send_frame(F_23);
    send_frame(F_F0);
    send_frame(F_2B);
    wait_drain("other_break", HOLD + 200);

    // break_pending was cleared, so 23 now is a make
    expect_ev(EV_MAKE, int'(F_23));
    send_frame(F_23);
    wait_drain("break_cleared", 50);

    // Reset mid-frame during a hold
    expect_ev(EV_END, 0);
    send_bits(F_1C, 4);
    rst = 1'b1;
    cyc(3);
    check("midrst_sda", int'(sda_to_do), 0);
    check("midrst_valid", int'(data_valid), 1);
    check("midrst_err", int'(frame_err), 0);
    rst = 1'b0;
    wait_drain("midrst_end", 5);
    cyc(20);
    expect_ev(EV_MAKE, int'(F_2B));
    expect_ev(EV_END, HOLD);
    send_frame(F_2B);
    wait_drain("after_rst_2B", HOLD + 200);

    // Partial frame times out, next full frame decodes
    expect_ev(EV_ERR, 0);
    send_bits(F_1C, 5);
    wait_drain("timeout", TMO + 100);
    expect_ev(EV_MAKE, int'(F_34));
    expect_ev(EV_END, HOLD);
    send_frame(F_34);
    wait_drain("after_timeout_34", HOLD + 200);

    // Short clock glitch must not shift a bit
    ps2_clk = 1'b0;
    cyc(3);
    ps2_clk = 1'b1;
    cyc(30);
    expect_ev(EV_MAKE, int'(F_1C));
    expect_ev(EV_END, HOLD);
    send_frame(F_1C);
    wait_drain("glitch_1C", HOLD + 200);

    cyc(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
